// File: rtl/io_byte_sequencer.sv
// io_byte_sequencer
//   Sequences 16-bit CPU I/O cycles onto the 8-bit peripheral bus. A word
//   access becomes 0, 1 or 2 byte transactions, routed to one of NDEV devices.
//   Both the CPU side and the device side use a toggle handshake: a request is
//   pending while req != ack.
//
//   Optional feature macro: IOSEQ_TIMEOUT_EN
//     defined   - a device that does not ack within TIMEOUT cycles has its byte
//                 phase abandoned. The lane reads 8'hFF and timeout pulses.
//     undefined - WAIT holds until the device acks, and timeout stays 0.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   cpu_req / cpu_ack     CPU toggle handshake
//   cpu_wr, cpu_addr      access direction and port address
//   cpu_bhe_n, cpu_din    byte-high enable (active low), write data
//   cpu_dout              read result, valid once cpu_ack == cpu_req
//   dev_id, dev_valid     target device from the address decoder, mapped flag
//   io_addr, io_dout      byte address and byte write data to the devices
//   io_rd_req/io_rd_ack   per-device read toggles
//   io_wr_req/io_wr_ack   per-device write toggles
//   io_din                per-device read bytes, device k on [8k+7:8k]
//   busy                  FSM not idle
//   timeout               one-cycle pulse when a byte phase is abandoned
module io_byte_sequencer #(
    parameter int  NDEV    = 4,
    parameter int  TIMEOUT = 255,
    localparam int IDX_W   = (NDEV > 1) ? $clog2(NDEV) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    output logic              cpu_ack,
    input  logic              cpu_wr,
    input  logic [15:0]       cpu_addr,
    input  logic              cpu_bhe_n,
    input  logic [15:0]       cpu_din,
    output logic [15:0]       cpu_dout,
    input  logic [IDX_W-1:0]  dev_id,
    input  logic              dev_valid,
    output logic [15:0]       io_addr,
    output logic [7:0]        io_dout,
    output logic [NDEV-1:0]   io_rd_req,
    input  logic [NDEV-1:0]   io_rd_ack,
    output logic [NDEV-1:0]   io_wr_req,
    input  logic [NDEV-1:0]   io_wr_ack,
    input  logic [NDEV*8-1:0] io_din,
    output logic              busy,
    output logic              timeout
);

    typedef enum logic [2:0] {
        IDLE, LO_ISSUE, LO_WAIT, HI_ISSUE, HI_WAIT, DONE
    } state_t;

`ifdef IOSEQ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t           state;
    logic [15:0]      a_addr;
    logic [15:0]      a_din;
    logic             a_wr;
    logic [IDX_W-1:0] a_id;
    logic             hi_pend;     // a high-byte phase follows the low one
    logic [NDEV-1:0]  rd_mir;      // local copy of the ack each device is expected to hold
    logic [NDEV-1:0]  wr_mir;
    logic [7:0]       wait_cnt;

    logic       ack_seen;
    logic       tmo_hit;
    logic [7:0] lane_byte;

    // Completion is detected as a toggle of the device ack relative to the
    // mirror. On an abandoned phase the mirror is flipped anyway. A late ack
    // then lands on the mirror value and produces no toggle, so it is ignored.
    assign ack_seen  = a_wr ? (io_wr_ack[a_id] != wr_mir[a_id])
                            : (io_rd_ack[a_id] != rd_mir[a_id]);
    assign tmo_hit   = TMO_EN && !ack_seen && (wait_cnt == TMO_LAST);
    assign lane_byte = ack_seen ? io_din[{a_id, 3'b000} +: 8] : 8'hFF;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cpu_ack   <= 1'b0;
            cpu_dout  <= 16'hFFFF;
            io_addr   <= 16'h0000;
            io_dout   <= 8'h00;
            io_rd_req <= '0;
            io_wr_req <= '0;
            rd_mir    <= '0;
            wr_mir    <= '0;
            timeout   <= 1'b0;
            a_addr    <= 16'h0000;
            a_din     <= 16'h0000;
            a_wr      <= 1'b0;
            a_id      <= '0;
            hi_pend   <= 1'b0;
            wait_cnt  <= 8'd0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req != cpu_ack) begin
                        a_addr   <= cpu_addr;
                        a_din    <= cpu_din;
                        a_wr     <= cpu_wr;
                        a_id     <= dev_id;
                        hi_pend  <= ~cpu_bhe_n;
                        cpu_dout <= 16'hFFFF;
                        // Unmapped ports, and accesses with neither byte enabled, skip the bus.
                        if (!dev_valid || (cpu_addr[0] && cpu_bhe_n))
                            state <= DONE;
                        else if (!cpu_addr[0])
                            state <= LO_ISSUE;
                        else
                            state <= HI_ISSUE;
                    end
                end
                LO_ISSUE, HI_ISSUE: begin
                    if (state == LO_ISSUE) begin
                        io_addr <= a_addr;
                        io_dout <= a_din[7:0];
                        state   <= LO_WAIT;
                    end else begin
                        io_addr <= {a_addr[15:1], 1'b1};
                        io_dout <= a_din[15:8];
                        state   <= HI_WAIT;
                    end
                    if (a_wr) io_wr_req[a_id] <= ~io_wr_req[a_id];
                    else      io_rd_req[a_id] <= ~io_rd_req[a_id];
                    wait_cnt <= 8'd0;
                end
                LO_WAIT, HI_WAIT: begin
                    if (ack_seen || tmo_hit) begin
                        if (a_wr) wr_mir[a_id] <= ~wr_mir[a_id];
                        else      rd_mir[a_id] <= ~rd_mir[a_id];
                        if (!a_wr) begin
                            if (state == LO_WAIT) cpu_dout[7:0]  <= lane_byte;
                            else                  cpu_dout[15:8] <= lane_byte;
                        end
                        timeout <= tmo_hit;
                        state   <= (state == LO_WAIT && hi_pend) ? HI_ISSUE : DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    cpu_ack <= ~cpu_ack;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_byte_sequencer.sv
// Testbench for io_byte_sequencer: table of CPU accesses with expected read
// data and device-toggle counts, scoreboarded against the CPU ack, plus
// hand-written sequences for back-to-back requests, reset in the middle of a
// transfer and (with IOSEQ_TIMEOUT_EN) a device that never answers.
module tb_io_byte_sequencer;
    localparam int NDEV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_wr = 1'b0, cpu_bhe_n = 1'b1, dev_valid = 1'b0;
    logic [15:0] cpu_addr = 16'h0, cpu_din = 16'h0;
    logic [1:0]  dev_id = 2'd0;
    logic        cpu_ack, busy, timeout;
    logic [15:0] cpu_dout, io_addr;
    logic [7:0]  io_dout;
    logic [NDEV-1:0] io_rd_req, io_wr_req, rd_ack, wr_ack;
    logic [NDEV*8-1:0] io_din;

    always #5 clk = ~clk;

    io_byte_sequencer #(.NDEV(NDEV), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_ack(cpu_ack),
        .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_bhe_n(cpu_bhe_n),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .dev_id(dev_id),
        .dev_valid(dev_valid), .io_addr(io_addr), .io_dout(io_dout),
        .io_rd_req(io_rd_req), .io_rd_ack(rd_ack), .io_wr_req(io_wr_req),
        .io_wr_ack(wr_ack), .io_din(io_din), .busy(busy), .timeout(timeout)
    );

    // ---------------- device model ----------------
    typedef struct {
        int          dev;
        logic [15:0] addr;
        logic [7:0]  data;
    } wlog_t;

    logic [7:0] dev_rdata [NDEV];
    bit         mute [NDEV];
    int         rd_tog [NDEV];
    int         wr_tog [NDEV];
    logic [NDEV-1:0] prev_rd, prev_wr;
    wlog_t      act_log[$];
    wlog_t      exp_log[$];
    int         tmo_pulses = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ack  <= '0;
            wr_ack  <= '0;
            io_din  <= '1;
            prev_rd <= '0;
            prev_wr <= '0;
        end else begin
            prev_rd <= io_rd_req;
            prev_wr <= io_wr_req;
            for (int k = 0; k < NDEV; k++) begin
                if (io_rd_req[k] != prev_rd[k]) rd_tog[k] <= rd_tog[k] + 1;
                if (io_wr_req[k] != prev_wr[k]) wr_tog[k] <= wr_tog[k] + 1;
                if (io_rd_req[k] != rd_ack[k] && !mute[k]) begin
                    rd_ack[k]       <= io_rd_req[k];
                    io_din[k*8 +: 8] <= dev_rdata[k];
                end
                if (io_wr_req[k] != wr_ack[k] && !mute[k]) begin
                    wr_ack[k] <= io_wr_req[k];
                    act_log.push_back('{k, io_addr, io_dout});
                end
            end
        end
    end

    always @(posedge clk) if (timeout) tmo_pulses <= tmo_pulses + 1;

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int sum_rd();
        int s = 0;
        for (int k = 0; k < NDEV; k++) s += rd_tog[k];
        return s;
    endfunction

    function automatic int sum_wr();
        int s = 0;
        for (int k = 0; k < NDEV; k++) s += wr_tog[k];
        return s;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cpu_ack"},   cpu_ack, 1'b0);
        chk({tag, "_busy"},      busy, 1'b0);
        chk({tag, "_timeout"},   timeout, 1'b0);
        chk({tag, "_cpu_dout"},  cpu_dout, 16'hFFFF);
        chk({tag, "_io_addr"},   io_addr, 16'h0000);
        chk({tag, "_io_dout"},   io_dout, 8'h00);
        chk({tag, "_io_rd_req"}, io_rd_req, 4'h0);
        chk({tag, "_io_wr_req"}, io_wr_req, 4'h0);
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic        bhe_n;
        logic [15:0] din;
        logic [1:0]  id;
        logic        valid;
        logic [7:0]  rdata;
        logic [15:0] exp_dout;
        int          exp_tog;
        int          max_cyc;
    } vec_t;

    vec_t sb[$];

    task automatic run_vec(input vec_t v);
        int    rd0, wr0, cyc;
        vec_t  e;
        wlog_t a, x;
        rd0 = sum_rd();
        wr0 = sum_wr();
        dev_rdata[v.id] = v.rdata;
        if (v.wr && v.valid) begin
            if (!v.addr[0]) exp_log.push_back('{int'(v.id), v.addr, v.din[7:0]});
            if (!v.bhe_n)   exp_log.push_back('{int'(v.id), v.addr | 16'h1, v.din[15:8]});
        end
        @(negedge clk);
        cpu_wr = v.wr; cpu_addr = v.addr; cpu_bhe_n = v.bhe_n; cpu_din = v.din;
        dev_id = v.id; dev_valid = v.valid;
        sb.push_back(v);
        cpu_req = ~cpu_req;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (cpu_ack != cpu_req && cyc < 40);
        e = sb.pop_front();
        chk("ack_in_time", (cyc <= e.max_cyc && cpu_ack == cpu_req), 1'b1);
        @(negedge clk);
        chk("cpu_dout", cpu_dout, e.exp_dout);
        chk("dev_toggles", (sum_rd() - rd0) + (sum_wr() - wr0), e.exp_tog);
        chk("wrong_dir_toggles", e.wr ? (sum_rd() - rd0) : (sum_wr() - wr0), 0);
        if (e.valid && !(e.addr[0] && e.bhe_n))
            chk("io_addr_last", io_addr, e.bhe_n ? e.addr : (e.addr | 16'h1));
        chk("wlog_count", act_log.size(), exp_log.size());
        while (act_log.size() > 0 && exp_log.size() > 0) begin
            a = act_log.pop_front();
            x = exp_log.pop_front();
            chk("wlog_dev",  a.dev,  x.dev);
            chk("wlog_addr", a.addr, x.addr);
            chk("wlog_data", a.data, x.data);
        end
        act_log.delete();
        exp_log.delete();
    endtask

    vec_t vecs[9];
    vec_t hv;
    int   rd0, cyc, p0;

    initial begin
        for (int k = 0; k < NDEV; k++) begin
            dev_rdata[k] = 8'h00; mute[k] = 1'b0; rd_tog[k] = 0; wr_tog[k] = 0;
        end
        //           wr    addr      bhe_n din       id    valid rdata  exp_dout  tog max
        vecs[0] = '{1'b0, 16'h0040, 1'b1, 16'h0000, 2'd1, 1'b1, 8'h5A, 16'hFF5A, 1, 40};
        vecs[1] = '{1'b1, 16'h00B0, 1'b0, 16'hBEEF, 2'd0, 1'b1, 8'h00, 16'hFFFF, 2, 40};
        vecs[2] = '{1'b0, 16'h0021, 1'b0, 16'h0000, 2'd2, 1'b1, 8'h3C, 16'h3CFF, 1, 40};
        vecs[3] = '{1'b0, 16'h0300, 1'b0, 16'h0000, 2'd1, 1'b0, 8'h66, 16'hFFFF, 0, 3};
        vecs[4] = '{1'b0, 16'h0010, 1'b0, 16'h0000, 2'd3, 1'b1, 8'h77, 16'h7777, 2, 40};
        vecs[5] = '{1'b0, 16'h0011, 1'b1, 16'h0000, 2'd0, 1'b1, 8'h12, 16'hFFFF, 0, 3};
        vecs[6] = '{1'b1, 16'h0045, 1'b0, 16'h1234, 2'd1, 1'b1, 8'h00, 16'hFFFF, 1, 40};
        vecs[7] = '{1'b1, 16'h0202, 1'b0, 16'h5555, 2'd2, 1'b0, 8'h00, 16'hFFFF, 0, 3};
        vecs[8] = '{1'b0, 16'h0008, 1'b0, 16'h0000, 2'd0, 1'b1, 8'hA5, 16'hA5A5, 2, 40};

        #1 reset = 1'b1;
        #1 chk_reset_vals("por");
        repeat (3) @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // A second CPU toggle during a transfer is serviced after the first.
        dev_rdata[1] = 8'h5A;
        rd0 = sum_rd();
        @(negedge clk);
        cpu_wr = 1'b0; cpu_addr = 16'h0040; cpu_bhe_n = 1'b1; dev_id = 2'd1; dev_valid = 1'b1;
        cpu_req = ~cpu_req;
        @(negedge clk);
        cpu_req = ~cpu_req;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!(sum_rd() - rd0 == 2 && cpu_ack == cpu_req && !busy) && cyc < 60);
        chk("queued_req_serviced", cyc < 60, 1'b1);
        chk("queued_req_toggles", sum_rd() - rd0, 2);
        chk("queued_req_dout", cpu_dout, 16'hFF5A);

        // Reset while the high byte of a read is stuck waiting.
        mute[2] = 1'b1;
        @(negedge clk);
        cpu_wr = 1'b0; cpu_addr = 16'h0021; cpu_bhe_n = 1'b0; dev_id = 2'd2; dev_valid = 1'b1;
        cpu_req = ~cpu_req;
        repeat (6) @(negedge clk);
        chk("stuck_busy", busy, 1'b1);
        chk("stuck_io_addr", io_addr, 16'h0021);
        reset = 1'b1;
        cpu_req = 1'b0;
        #1 chk_reset_vals("midop");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mute[2] = 1'b0;
        hv = '{1'b0, 16'h0020, 1'b1, 16'h0000, 2'd2, 1'b1, 8'h42, 16'hFF42, 1, 40};
        run_vec(hv);

`ifdef IOSEQ_TIMEOUT_EN
        // Device 3 never answers: the phase is abandoned, the late ack is dropped.
        mute[3] = 1'b1;
        p0 = tmo_pulses;
        hv = '{1'b0, 16'h0030, 1'b1, 16'h0000, 2'd3, 1'b1, 8'h00, 16'hFFFF, 1, 40};
        run_vec(hv);
        chk("timeout_pulses", tmo_pulses - p0, 1);
        mute[3] = 1'b0;
        repeat (4) @(negedge clk);
        chk("late_ack_busy", busy, 1'b0);
        chk("late_ack_cpu_ack", cpu_ack, cpu_req);
        hv = '{1'b0, 16'h0030, 1'b1, 16'h0000, 2'd3, 1'b1, 8'h99, 16'hFF99, 1, 40};
        run_vec(hv);
`else
        p0 = 0;
        chk("timeout_tied_low", tmo_pulses, p0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
